gpio_dglitch_mc: RTL and testbench

Multi-channel, parametrised GPIO de-glitch filter with programmable stability count, selectable sample tick and per-channel edge detection. Sits between the pad-side GPIO inputs and the GPIO register/interrupt logic. Each channel has its own synchroniser, stability counter and rise/fall pulse generation.

---
 rtl/gpio_dglitch_pkg.sv | 13 +
 rtl/gpio_dglitch_ch.sv | 63 ++++++
 rtl/gpio_dglitch_mc.sv | 51 +++++
 tb/tb_gpio_dglitch_mc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_dglitch_pkg.sv
// Shared types and defaults for the GPIO de-glitch filter.
package gpio_dglitch_pkg;

  typedef enum logic [1:0] {
    DG_TICK_1US  = 2'd0,
    DG_TICK_CLK  = 2'd1,
    DG_TICK_1MS  = 2'd2,
    DG_TICK_RSVD = 2'd3
  } dg_tick_e;

  localparam int unsigned DG_CNT_W = 4;

endpackage

// File: rtl/gpio_dglitch_ch.sv
// One de-glitch channel: 2-flop synchroniser, stability counter, filtered level and edge pulses.
module gpio_dglitch_ch #(
  parameter int unsigned CNT_W   = gpio_dglitch_pkg::DG_CNT_W,
  parameter logic        RST_BIT = 1'b0
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic             en,
  input  logic             din,
  output logic             dout,
  output logic             rise,
  output logic             fall
);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             out_next;
  logic [CNT_W:0]   cnt_inc;

  // Extra bit keeps the compare exact even when cnt is at its maximum
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    out_next = dout;
    cnt_next = cnt;
    if (!en) begin
      cnt_next = '0;
    end else if (cfg_cnt == '0) begin
      out_next = sync2;
      cnt_next = '0;
    end else if (tick) begin
      if (sync2 == dout) begin
        cnt_next = '0;
      end else if (cnt_inc >= {1'b0, cfg_cnt}) begin
        out_next = sync2;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RST_BIT;
      sync2 <= RST_BIT;
      cnt   <= '0;
      dout  <= RST_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cnt   <= cnt_next;
      dout  <= out_next;
      rise  <= out_next & ~dout;
      fall  <= ~out_next & dout;
    end
  end

endmodule

// File: rtl/gpio_dglitch_mc.sv
// Multi-channel GPIO de-glitch filter: shared sample-tick select, one filter channel per GPIO.
module gpio_dglitch_mc
  import gpio_dglitch_pkg::*;
#(
  parameter int unsigned     NCH     = 32,
  parameter int unsigned     CNT_W   = DG_CNT_W,
  parameter logic [NCH-1:0]  RST_VAL = '0
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             pulse_1us,
  input  logic             pulse_1ms,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic [NCH-1:0]   cfg_ch_en,
  input  logic [NCH-1:0]   gpio_in,
  output logic [NCH-1:0]   gpio_out,
  output logic [NCH-1:0]   gpio_rise,
  output logic [NCH-1:0]   gpio_fall
);

  logic tick;

  // Reserved mode falls through to the every-clock tick
  always_comb begin
    tick = 1'b1;
    case (dg_tick_e'(cfg_mode))
      DG_TICK_1US: tick = pulse_1us;
      DG_TICK_1MS: tick = pulse_1ms;
      default:     tick = 1'b1;
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gpio_dglitch_ch #(
      .CNT_W   (CNT_W),
      .RST_BIT (RST_VAL[i])
    ) u_ch (
      .mclk    (mclk),
      .reset_n (reset_n),
      .tick    (tick),
      .cfg_cnt (cfg_cnt),
      .en      (cfg_ch_en[i]),
      .din     (gpio_in[i]),
      .dout    (gpio_out[i]),
      .rise    (gpio_rise[i]),
      .fall    (gpio_fall[i])
    );
  end

endmodule

// File: tb/tb_gpio_dglitch_mc.sv
// Directed bench for gpio_dglitch_mc: 8 channels, RST_VAL = 8'hF0, hand-computed expectations.
module tb_gpio_dglitch_mc;

  localparam int unsigned NCH   = 8;
  localparam int unsigned CNT_W = 4;

  logic             mclk = 1'b0;
  logic             reset_n;
  logic             pulse_1us, pulse_1ms;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_cnt;
  logic [NCH-1:0]   cfg_ch_en, gpio_in;
  logic [NCH-1:0]   gpio_out, gpio_rise, gpio_fall;

  int vectors = 0;
  int errors  = 0;
  int tphase  = 0;

  gpio_dglitch_mc #(
    .NCH     (NCH),
    .CNT_W   (CNT_W),
    .RST_VAL (8'hF0)
  ) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .pulse_1us (pulse_1us),
    .pulse_1ms (pulse_1ms),
    .cfg_mode  (cfg_mode),
    .cfg_cnt   (cfg_cnt),
    .cfg_ch_en (cfg_ch_en),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_rise (gpio_rise),
    .gpio_fall (gpio_fall)
  );

  always #5 mclk = ~mclk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // pulse_1us is high for the one edge where the 50-cycle phase is zero
  task automatic tick_steps(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      pulse_1us = (tphase == 0);
      step(1);
      tphase = (tphase + 1) % 50;
    end
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    pulse_1us = 1'b0;
    pulse_1ms = 1'b0;
    cfg_mode  = 2'd1;
    cfg_cnt   = 4'd3;
    cfg_ch_en = 8'hFF;
    gpio_in   = 8'h00;

    // Reset values, then ch4-7 fall from their reset level
    step(2);
    chk("rst_out", gpio_out, 8'hF0);
    chk("rst_rise", gpio_rise, 8'h00);
    chk("rst_fall", gpio_fall, 8'h00);
    reset_n = 1'b1;
    step(1);
    chk("rel_out", gpio_out, 8'hF0);
    chk("rel_fall", gpio_fall, 8'h00);
    step(3);
    chk("rel4_out", gpio_out, 8'hF0);
    chk("rel4_fall", gpio_fall, 8'h00);
    step(1);
    chk("rel5_out", gpio_out, 8'h00);
    chk("rel5_fall", gpio_fall, 8'hF0);
    step(1);
    chk("rel6_fall", gpio_fall, 8'h00);

    // ch0 step: output 5 edges after the drive edge
    gpio_in = 8'h01;
    step(4);
    chk("step4_out", gpio_out, 8'h00);
    step(1);
    chk("step5_out", gpio_out, 8'h01);
    chk("step5_rise", gpio_rise, 8'h01);
    step(1);
    chk("step6_rise", gpio_rise, 8'h00);
    chk("step6_out", gpio_out, 8'h01);
    gpio_in = 8'h00;
    step(5);
    chk("stepdn_out", gpio_out, 8'h00);
    chk("stepdn_fall", gpio_fall, 8'h01);

    // ch1 glitch of 2 cycles is rejected
    gpio_in = 8'h02;
    step(2);
    gpio_in = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("gl2_out", gpio_out, 8'h00);
      chk("gl2_rise", gpio_rise, 8'h00);
    end

    // ch1 glitch of 3 cycles passes, then returns
    gpio_in = 8'h02;
    step(3);
    gpio_in = 8'h00;
    step(2);
    chk("gl3_out", gpio_out, 8'h02);
    chk("gl3_rise", gpio_rise, 8'h02);
    step(3);
    chk("gl3_ret_out", gpio_out, 8'h00);
    chk("gl3_ret_fall", gpio_fall, 8'h02);

    // Mode 0, cfg_cnt=2: ticks land on edges 11, 61, 111 after this point
    cfg_mode = 2'd0;
    cfg_cnt  = 4'd2;
    tphase   = 40;
    gpio_in  = 8'h04;
    tick_steps(60);
    chk("us_pre_out", gpio_out, 8'h00);
    tick_steps(1);
    chk("us_out", gpio_out, 8'h04);
    chk("us_rise", gpio_rise, 8'h04);
    tick_steps(1);
    chk("us_rise_end", gpio_rise, 8'h00);
    // Low across a single tick only: no change
    gpio_in = 8'h00;
    tick_steps(60);
    chk("us_1tick_out", gpio_out, 8'h04);
    gpio_in = 8'h04;
    tick_steps(45);
    chk("us_1tick_out2", gpio_out, 8'h04);
    chk("us_1tick_fall", gpio_fall, 8'h00);
    pulse_1us = 1'b0;

    // Bypass: output follows the synchroniser
    cfg_mode = 2'd1;
    cfg_cnt  = 4'd0;
    gpio_in  = 8'h5A;
    step(2);
    chk("byp2_out", gpio_out, 8'h04);
    step(1);
    chk("byp3_out", gpio_out, 8'h5A);
    chk("byp3_rise", gpio_rise, 8'h5A);
    chk("byp3_fall", gpio_fall, 8'h04);

    // Disabled ch3 stays frozen while its input toggles
    cfg_ch_en = 8'hF7;
    gpio_in   = 8'h52;
    step(3);
    chk("dis_out", gpio_out, 8'h5A);
    chk("dis_fall", gpio_fall, 8'h00);
    gpio_in = 8'h5A;
    step(3);
    chk("dis_out2", gpio_out, 8'h5A);
    chk("dis_rise", gpio_rise, 8'h00);
    cfg_ch_en = 8'hFF;

    // Lower cfg_cnt mid-count: cnt=5, cfg_cnt 10 -> 4 updates on next tick
    cfg_cnt = 4'd10;
    gpio_in = 8'h5B;
    step(7);
    chk("mid_pre_out", gpio_out, 8'h5A);
    cfg_cnt = 4'd4;
    step(1);
    chk("mid_out", gpio_out, 8'h5B);
    chk("mid_rise", gpio_rise, 8'h01);

    // Reset mid-count returns immediately to reset values
    cfg_cnt = 4'd10;
    gpio_in = 8'h5A;
    step(5);
    chk("mrst_pre_out", gpio_out, 8'h5B);
    reset_n = 1'b0;
    #1;
    chk("mrst_out", gpio_out, 8'hF0);
    chk("mrst_rise", gpio_rise, 8'h00);
    chk("mrst_fall", gpio_fall, 8'h00);
    step(2);

    // Mode 2 uses pulse_1ms only; pulse_1us held high is ignored
    gpio_in   = 8'h01;
    pulse_1us = 1'b1;
    cfg_mode  = 2'd2;
    cfg_cnt   = 4'd1;
    reset_n   = 1'b1;
    step(5);
    chk("ms_pre_out", gpio_out, 8'hF0);
    chk("ms_pre_fall", gpio_fall, 8'h00);
    pulse_1ms = 1'b1;
    step(1);
    pulse_1ms = 1'b0;
    chk("ms_out", gpio_out, 8'h01);
    chk("ms_rise", gpio_rise, 8'h01);
    chk("ms_fall", gpio_fall, 8'hF0);

    // Reserved mode ticks every clock
    cfg_mode = 2'd3;
    gpio_in  = 8'h03;
    step(2);
    chk("rsvd_pre_out", gpio_out, 8'h01);
    step(1);
    chk("rsvd_out", gpio_out, 8'h03);
    chk("rsvd_rise", gpio_rise, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
